// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution queue.
// Queue entries use the package widths; keep the top-level parameters in step with them.
package branch_pkg;

  localparam int unsigned BRQ_DATA_W      = 16;
  localparam int unsigned BRQ_PRED_DEPTH  = 64;
  localparam int unsigned BRQ_IDX_W       = (BRQ_PRED_DEPTH == 1) ? 1 : $clog2(BRQ_PRED_DEPTH);
  localparam int unsigned BRQ_QUEUE_DEPTH = 4;
  localparam int unsigned BRQ_STAT_W      = 16;

  // 2-bit saturating predictor encoding
  localparam logic [1:0] PRED_STRONG_NT = 2'b00;
  localparam logic [1:0] PRED_WEAK_NT   = 2'b01;
  localparam logic [1:0] PRED_WEAK_T    = 2'b10;
  localparam logic [1:0] PRED_STRONG_T  = 2'b11;

  // State a BTB entry takes after reset
  localparam logic [1:0] BTB_RESET_STATE = PRED_WEAK_NT;

  // One in-flight branch as captured at fetch time
  typedef struct packed {
    logic [BRQ_IDX_W-1:0]  index;
    logic                  pred_valid;
    logic [1:0]            prediction;
    logic [BRQ_DATA_W-1:0] pred_dest;
    logic [BRQ_DATA_W-1:0] fall_through;
    logic                  reg_branch;
  } brq_entry_t;

  // A lookup counts as predicted-taken only when it hit and is in a taken state
  function automatic logic pred_taken(input logic pred_valid, input logic [1:0] prediction);
    return pred_valid && ((prediction == PRED_WEAK_T) || (prediction == PRED_STRONG_T));
  endfunction

  // Saturating increment for the statistics counters
  function automatic logic [BRQ_STAT_W-1:0] sat_inc(input logic [BRQ_STAT_W-1:0] val);
    return (val == {BRQ_STAT_W{1'b1}}) ? val : val + BRQ_STAT_W'(1);
  endfunction

endpackage

// File: rtl/brq_mispredict_check.sv
// Compares the oldest queued prediction with the execute outcome.
module brq_mispredict_check
  import branch_pkg::*;
#(
  parameter int unsigned DATABITWIDTH = BRQ_DATA_W
) (
  input  logic                    head_pred_valid,
  input  logic [1:0]              head_prediction,
  input  logic                    head_reg_branch,
  input  logic [DATABITWIDTH-1:0] head_pred_dest,
  input  logic                    resolve_taken,
  input  logic [DATABITWIDTH-1:0] resolve_dest,
  output logic                    mispredict_c
);

  logic pred_taken_c;
  logic dest_wrong_c;

  // Direction mismatch, or a taken register branch that went somewhere else
  always_comb begin
    pred_taken_c = pred_taken(head_pred_valid, head_prediction);
    dest_wrong_c = resolve_taken && head_reg_branch && (head_pred_dest != resolve_dest);
    mispredict_c = (pred_taken_c != resolve_taken) || dest_wrong_c;
  end

endmodule

// File: rtl/branch_resolution_queue.sv
// In-order queue of fetched branches; resolves the oldest against execute,
// emits a one-cycle BTB update and, on mispredict, a fetch redirect.
// Optional macro BRANCH_RESOLUTION_STATS_EN adds ResolvedCount/MispredictCount.
module branch_resolution_queue
  import branch_pkg::*;
#(
  parameter  int unsigned DATABITWIDTH           = BRQ_DATA_W,
  parameter  int unsigned PREDICTORDEPTH         = BRQ_PRED_DEPTH,
  parameter  int unsigned QUEUEDEPTH             = BRQ_QUEUE_DEPTH,
  localparam int unsigned PREDICTORINDEXBITWIDTH = (PREDICTORDEPTH == 1) ? 1 : $clog2(PREDICTORDEPTH),
  localparam int unsigned OCC_W                  = $clog2(QUEUEDEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              sync_rst_n,
  input  logic                              clk_en,
  input  logic                              PushValid,
  output logic                              PushReady,
  input  logic [PREDICTORINDEXBITWIDTH-1:0] PushIndex,
  input  logic                              PushPredValid,
  input  logic [1:0]                        PushPrediction,
  input  logic [DATABITWIDTH-1:0]           PushPredDest,
  input  logic [DATABITWIDTH-1:0]           PushFallThrough,
  input  logic                              PushRegBranch,
  input  logic                              ResolveValid,
  input  logic                              ResolveTaken,
  input  logic [DATABITWIDTH-1:0]           ResolveDest,
  input  logic                              FlushAll,
  output logic                              UpdateEnable,
  output logic [PREDICTORINDEXBITWIDTH-1:0] UpdateAddress,
  output logic                              UpdateRegBranch,
  output logic                              UpdateTaken,
  output logic [DATABITWIDTH-1:0]           UpdateDest,
  output logic                              Mispredict,
  output logic [DATABITWIDTH-1:0]           RedirectDest,
  output logic [OCC_W-1:0]                  Occupancy
`ifdef BRANCH_RESOLUTION_STATS_EN
  ,
  output logic [BRQ_STAT_W-1:0]             ResolvedCount,
  output logic [BRQ_STAT_W-1:0]             MispredictCount
`endif
);

  localparam int unsigned PTR_W = OCC_W - 1;

  // Pointers carry one extra wrap bit to tell full from empty
  logic [OCC_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]                  rd_ptr_q, rd_ptr_d;
  brq_entry_t                        entries_q [QUEUEDEPTH];
  brq_entry_t                        entries_d [QUEUEDEPTH];

  logic                              update_en_q, update_en_d;
  logic [PREDICTORINDEXBITWIDTH-1:0] update_addr_q, update_addr_d;
  logic                              update_reg_branch_q, update_reg_branch_d;
  logic                              update_taken_q, update_taken_d;
  logic [DATABITWIDTH-1:0]           update_dest_q, update_dest_d;
  logic                              mispredict_q, mispredict_d;
  logic [DATABITWIDTH-1:0]           redirect_dest_q, redirect_dest_d;
`ifdef BRANCH_RESOLUTION_STATS_EN
  logic [BRQ_STAT_W-1:0]             resolved_cnt_q, resolved_cnt_d;
  logic [BRQ_STAT_W-1:0]             mispredict_cnt_q, mispredict_cnt_d;
`endif

  logic                              empty_c;
  logic                              full_c;
  logic                              push_fire_c;
  logic                              resolve_fire_c;
  logic                              kill_c;
  logic                              mispredict_c;
  brq_entry_t                        head_c;
  brq_entry_t                        push_entry_c;

  // Queue status and the oldest entry
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    head_c  = entries_q[rd_ptr_q[PTR_W-1:0]];
  end

  brq_mispredict_check #(
    .DATABITWIDTH (DATABITWIDTH)
  ) u_check (
    .head_pred_valid (head_c.pred_valid),
    .head_prediction (head_c.prediction),
    .head_reg_branch (head_c.reg_branch),
    .head_pred_dest  (DATABITWIDTH'(head_c.pred_dest)),
    .resolve_taken   (ResolveTaken),
    .resolve_dest    (ResolveDest),
    .mispredict_c    (mispredict_c)
  );

  // Handshake qualification; a mispredict or flush discards everything in flight
  always_comb begin
    push_fire_c    = clk_en && PushValid && !full_c;
    resolve_fire_c = clk_en && ResolveValid && !empty_c;
    kill_c         = (clk_en && FlushAll) || (resolve_fire_c && mispredict_c);

    push_entry_c.index        = BRQ_IDX_W'(PushIndex);
    push_entry_c.pred_valid   = PushPredValid;
    push_entry_c.prediction   = PushPrediction;
    push_entry_c.pred_dest    = BRQ_DATA_W'(PushPredDest);
    push_entry_c.fall_through = BRQ_DATA_W'(PushFallThrough);
    push_entry_c.reg_branch   = PushRegBranch;
  end

  // Next-state for pointers, storage and the update/redirect pulses
  always_comb begin
    wr_ptr_d            = wr_ptr_q;
    rd_ptr_d            = rd_ptr_q;
    entries_d           = entries_q;
    update_en_d         = 1'b0;
    update_addr_d       = update_addr_q;
    update_reg_branch_d = update_reg_branch_q;
    update_taken_d      = update_taken_q;
    update_dest_d       = update_dest_q;
    mispredict_d        = 1'b0;
    redirect_dest_d     = redirect_dest_q;
`ifdef BRANCH_RESOLUTION_STATS_EN
    resolved_cnt_d      = resolved_cnt_q;
    mispredict_cnt_d    = mispredict_cnt_q;
`endif

    if (push_fire_c && !kill_c) begin
      entries_d[wr_ptr_q[PTR_W-1:0]] = push_entry_c;
      wr_ptr_d                       = wr_ptr_q + OCC_W'(1);
    end

    if (resolve_fire_c) begin
      rd_ptr_d            = rd_ptr_q + OCC_W'(1);
      update_en_d         = 1'b1;
      update_addr_d       = PREDICTORINDEXBITWIDTH'(head_c.index);
      update_reg_branch_d = head_c.reg_branch;
      update_taken_d      = ResolveTaken;
      update_dest_d       = ResolveDest;
      mispredict_d        = mispredict_c;
      if (mispredict_c) begin
        redirect_dest_d = ResolveTaken ? ResolveDest : DATABITWIDTH'(head_c.fall_through);
      end
`ifdef BRANCH_RESOLUTION_STATS_EN
      resolved_cnt_d = sat_inc(resolved_cnt_q);
      if (mispredict_c) begin
        mispredict_cnt_d = sat_inc(mispredict_cnt_q);
      end
`endif
    end

    // Emptying is done by catching the read pointer up to the unadvanced write pointer
    if (kill_c) begin
      rd_ptr_d = wr_ptr_q;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      update_en_q         <= 1'b0;
      update_addr_q       <= '0;
      update_reg_branch_q <= 1'b0;
      update_taken_q      <= 1'b0;
      update_dest_q       <= '0;
      mispredict_q        <= 1'b0;
      redirect_dest_q     <= '0;
`ifdef BRANCH_RESOLUTION_STATS_EN
      resolved_cnt_q      <= '0;
      mispredict_cnt_q    <= '0;
`endif
    end else begin
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      update_en_q         <= update_en_d;
      update_addr_q       <= update_addr_d;
      update_reg_branch_q <= update_reg_branch_d;
      update_taken_q      <= update_taken_d;
      update_dest_q       <= update_dest_d;
      mispredict_q        <= mispredict_d;
      redirect_dest_q     <= redirect_dest_d;
`ifdef BRANCH_RESOLUTION_STATS_EN
      resolved_cnt_q      <= resolved_cnt_d;
      mispredict_cnt_q    <= mispredict_cnt_d;
`endif
    end
  end

  // Entry payload storage; validity is tracked purely by the pointers
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign PushReady       = !full_c;
  assign Occupancy       = wr_ptr_q - rd_ptr_q;
  assign UpdateEnable    = update_en_q;
  assign UpdateAddress   = update_addr_q;
  assign UpdateRegBranch = update_reg_branch_q;
  assign UpdateTaken     = update_taken_q;
  assign UpdateDest      = update_dest_q;
  assign Mispredict      = mispredict_q;
  assign RedirectDest    = redirect_dest_q;
`ifdef BRANCH_RESOLUTION_STATS_EN
  assign ResolvedCount   = resolved_cnt_q;
  assign MispredictCount = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Scoreboard bench: the driver keeps a queue-level model and posts expectations,
// the monitor compares them whenever the DUT's registered outputs settle.
module tb_branch_resolution_queue;

  localparam int QD = 4;

  typedef struct packed {
    logic [5:0]  idx;
    logic        pv;
    logic [1:0]  pred;
    logic [15:0] pd;
    logic [15:0] ft;
    logic        rb;
  } tb_entry_t;

  typedef struct {
    int          due;
    logic [5:0]  addr;
    logic        rb;
    logic        taken;
    logic [15:0] dest;
    logic        mis;
    logic [15:0] redir;
  } exp_upd_t;

  typedef struct {
    int due;
    int occ;
  } exp_occ_t;

  logic        clk = 1'b0;
  logic        sync_rst_n;
  logic        clk_en;
  logic        PushValid;
  logic        PushReady;
  logic [5:0]  PushIndex;
  logic        PushPredValid;
  logic [1:0]  PushPrediction;
  logic [15:0] PushPredDest;
  logic [15:0] PushFallThrough;
  logic        PushRegBranch;
  logic        ResolveValid;
  logic        ResolveTaken;
  logic [15:0] ResolveDest;
  logic        FlushAll;
  logic        UpdateEnable;
  logic [5:0]  UpdateAddress;
  logic        UpdateRegBranch;
  logic        UpdateTaken;
  logic [15:0] UpdateDest;
  logic        Mispredict;
  logic [15:0] RedirectDest;
  logic [2:0]  Occupancy;
`ifdef BRANCH_RESOLUTION_STATS_EN
  logic [15:0] ResolvedCount;
  logic [15:0] MispredictCount;
`endif

  branch_resolution_queue dut (
    .clk             (clk),
    .sync_rst_n      (sync_rst_n),
    .clk_en          (clk_en),
    .PushValid       (PushValid),
    .PushReady       (PushReady),
    .PushIndex       (PushIndex),
    .PushPredValid   (PushPredValid),
    .PushPrediction  (PushPrediction),
    .PushPredDest    (PushPredDest),
    .PushFallThrough (PushFallThrough),
    .PushRegBranch   (PushRegBranch),
    .ResolveValid    (ResolveValid),
    .ResolveTaken    (ResolveTaken),
    .ResolveDest     (ResolveDest),
    .FlushAll        (FlushAll),
    .UpdateEnable    (UpdateEnable),
    .UpdateAddress   (UpdateAddress),
    .UpdateRegBranch (UpdateRegBranch),
    .UpdateTaken     (UpdateTaken),
    .UpdateDest      (UpdateDest),
    .Mispredict      (Mispredict),
    .RedirectDest    (RedirectDest),
    .Occupancy       (Occupancy)
`ifdef BRANCH_RESOLUTION_STATS_EN
    ,
    .ResolvedCount   (ResolvedCount),
    .MispredictCount (MispredictCount)
`endif
  );

  always #5 clk = ~clk;

  int        cyc = 0;
  bit        rst_prev = 1'b1;
  int        n_checks = 0;
  int        n_errors = 0;
  exp_upd_t  upd_q[$];
  exp_occ_t  occ_q[$];
  tb_entry_t model_q[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= sync_rst_n;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] mon_redirect = 16'h0;
  int          mon_resolved = 0;
  int          mon_mispred  = 0;
  exp_upd_t    mu;
  exp_occ_t    mo;

  always @(negedge clk) begin
    if (!rst_prev) begin
      mon_redirect = 16'h0;
      mon_resolved = 0;
      mon_mispred  = 0;
      chk("rst_update_en", 32'(UpdateEnable), 32'd0);
      chk("rst_mispredict", 32'(Mispredict), 32'd0);
      chk("rst_update_addr", 32'(UpdateAddress), 32'd0);
      chk("rst_update_dest", 32'(UpdateDest), 32'd0);
      chk("rst_update_flags", 32'({UpdateRegBranch, UpdateTaken}), 32'd0);
    end
    if (UpdateEnable) begin
      if (upd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_update: UpdateEnable=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        mu = upd_q.pop_front();
        chk("update_time", 32'(cyc), 32'(mu.due));
        chk("update_addr", 32'(UpdateAddress), 32'(mu.addr));
        chk("update_regbranch", 32'(UpdateRegBranch), 32'(mu.rb));
        chk("update_taken", 32'(UpdateTaken), 32'(mu.taken));
        chk("update_dest", 32'(UpdateDest), 32'(mu.dest));
        chk("mispredict", 32'(Mispredict), 32'(mu.mis));
        mon_resolved++;
        if (mu.mis) begin
          mon_redirect = mu.redir;
          mon_mispred++;
        end
      end
    end else begin
      chk("mispredict_idle", 32'(Mispredict), 32'd0);
      if (upd_q.size() != 0 && upd_q[0].due <= cyc) begin
        mu = upd_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_update: no UpdateEnable for addr %0h due cycle %0d (cycle %0d)",
                 mu.addr, mu.due, cyc);
      end
    end
    chk("redirect_dest", 32'(RedirectDest), 32'(mon_redirect));
    while (occ_q.size() != 0 && occ_q[0].due <= cyc) begin
      mo = occ_q.pop_front();
      chk("occupancy", 32'(Occupancy), 32'(mo.occ));
      chk("push_ready", 32'(PushReady), 32'(mo.occ < QD));
    end
`ifdef BRANCH_RESOLUTION_STATS_EN
    chk("resolved_count", 32'(ResolvedCount), 32'(mon_resolved));
    chk("mispredict_count", 32'(MispredictCount), 32'(mon_mispred));
`endif
  end

  // ---------------- driver + reference model ----------------
  function automatic tb_entry_t mk(input logic [5:0] idx, input logic pv, input logic [1:0] pred,
                                   input logic [15:0] pd, input logic [15:0] ft, input logic rb);
    tb_entry_t e;
    e.idx = idx; e.pv = pv; e.pred = pred; e.pd = pd; e.ft = ft; e.rb = rb;
    return e;
  endfunction

  // Drive one clock worth of inputs and advance the model by the queue rules
  task automatic cycle(input bit rst_n, input bit en, input bit pv, input tb_entry_t e,
                       input bit rv, input bit rt, input logic [15:0] rdst, input bit fl);
    bit        was_full;
    bit        mis;
    tb_entry_t h;
    exp_upd_t  u;
    exp_occ_t  o;
    sync_rst_n      = rst_n;
    clk_en          = en;
    PushValid       = pv;
    PushIndex       = e.idx;
    PushPredValid   = e.pv;
    PushPrediction  = e.pred;
    PushPredDest    = e.pd;
    PushFallThrough = e.ft;
    PushRegBranch   = e.rb;
    ResolveValid    = rv;
    ResolveTaken    = rt;
    ResolveDest     = rdst;
    FlushAll        = fl;
    mis = 1'b0;
    if (!rst_n) begin
      model_q.delete();
    end else if (en) begin
      was_full = (model_q.size() == QD);
      if (rv && model_q.size() != 0) begin
        h       = model_q.pop_front();
        mis     = ((h.pv && h.pred[1]) != rt) || (rt && h.rb && (h.pd != rdst));
        u.due   = cyc + 1;
        u.addr  = h.idx;
        u.rb    = h.rb;
        u.taken = rt;
        u.dest  = rdst;
        u.mis   = mis;
        u.redir = rt ? rdst : h.ft;
        upd_q.push_back(u);
      end
      if (fl || mis) model_q.delete();
      else if (pv && !was_full) model_q.push_back(e);
    end
    o.due = cyc + 1;
    o.occ = model_q.size();
    occ_q.push_back(o);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic push(input tb_entry_t e);
    cycle(1'b1, 1'b1, 1'b1, e, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic resolve(input bit rt, input logic [15:0] rdst);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, rt, rdst, 1'b0);
  endtask

  task automatic rand_cycle();
    bit          rst_n, en, pv, rv, rt, fl;
    logic [15:0] rdst;
    tb_entry_t   e;
    rst_n = ($urandom_range(0, 199) != 0);
    en    = ($urandom_range(0, 9) != 0);
    pv    = ($urandom_range(0, 9) < 6);
    rv    = ($urandom_range(0, 9) < 4);
    fl    = ($urandom_range(0, 39) == 0);
    e     = mk(6'($urandom), 1'($urandom), 2'($urandom), {12'h0, 4'($urandom)},
               16'($urandom), 1'($urandom));
    rdst  = {12'h0, 4'($urandom)};
    rt    = 1'($urandom);
    if (model_q.size() != 0 && $urandom_range(0, 3) != 0) begin
      rt = model_q[0].pv && model_q[0].pred[1];
      if ($urandom_range(0, 1) != 0) rdst = model_q[0].pd;
    end
    cycle(rst_n, en, pv, e, rv, rt, rdst, fl);
  endtask

  initial begin
    // Reset
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    idle();

    // Correct taken prediction, update to index 5
    push(mk(6'd5, 1'b1, 2'b10, 16'h0040, 16'h0044, 1'b0));
    resolve(1'b1, 16'h0040);
    idle();

    // No prediction but taken: redirect to resolved target
    push(mk(6'd3, 1'b0, 2'b00, 16'h0000, 16'h0104, 1'b0));
    resolve(1'b1, 16'h0200);
    idle();

    // Register branch with wrong target flushes the younger entry too
    push(mk(6'd7, 1'b1, 2'b11, 16'h0300, 16'h0010, 1'b1));
    push(mk(6'd8, 1'b1, 2'b01, 16'h0500, 16'h0020, 1'b0));
    resolve(1'b1, 16'h0308);
    idle();

    // Fill, then push+resolve together: push refused while full
    for (int i = 0; i < 4; i++) push(mk(6'(10 + i), 1'b1, 2'b11, 16'(16'h0100 * i), 16'h0, 1'b0));
    cycle(1'b1, 1'b1, 1'b1, mk(6'd20, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0), 1'b1, 1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 3; i++) resolve(1'b1, 16'h0);
    idle();

    // Strong-taken resolved not-taken: redirect to fall-through
    push(mk(6'd9, 1'b1, 2'b11, 16'h0070, 16'h0010, 1'b0));
    resolve(1'b0, 16'h0070);
    idle();

    // Flush with a same-cycle resolve and push
    push(mk(6'd1, 1'b0, 2'b00, 16'h0, 16'h0002, 1'b0));
    push(mk(6'd2, 1'b0, 2'b00, 16'h0, 16'h0004, 1'b0));
    cycle(1'b1, 1'b1, 1'b1, mk(6'd4, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0), 1'b1, 1'b0, 16'h0, 1'b1);
    idle();

    // clk_en low: resolve and push ignored
    push(mk(6'd6, 1'b0, 2'b00, 16'h0, 16'h0006, 1'b0));
    cycle(1'b1, 1'b0, 1'b1, mk(6'd11, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0), 1'b1, 1'b1, 16'h0999, 1'b0);
    idle();

    // Reset asserted in the resolve cycle cancels the pulse
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 16'h0ABC, 1'b0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) rand_cycle();

    for (int i = 0; i < 4; i++) idle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
